// File: rtl/traffic_pkg.sv
// Shared types for the traffic light generator: controller states and the
// active-low seven-segment patterns {a,b,c,d,e,f,g} for digits 0-9.
package traffic_pkg;

    typedef enum logic [2:0] {
        S_G1, S_Y1, S_AR1, S_G2, S_Y2, S_AR2, S_NIGHT
    } state_t;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [9:0][6:0] SEG_LUT = {
        7'b0000100,  // 9
        7'b0000000,  // 8
        7'b0001111,  // 7
        7'b0100000,  // 6
        7'b0100100,  // 5
        7'b1001100,  // 4
        7'b0000110,  // 3
        7'b0010010,  // 2
        7'b1001111,  // 1
        7'b0000001   // 0
    };

    function automatic logic [6:0] seg7(input logic [3:0] d);
        return (d > 4'd9) ? SEG_BLANK : SEG_LUT[d];
    endfunction

endpackage

// File: rtl/seg_scan4.sv
// Two-digit multiplexed seven-segment driver; a blanked digit drives all
// segments off, and with both digits blanked every anode is released.
module seg_scan4
    import traffic_pkg::*;
#(
    parameter int SCAN_DIV = 100_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] d0,
    input  logic [3:0] d1,
    input  logic [1:0] blank,
    output logic [6:0] a_to_g,
    output logic [3:0] an
);

    localparam int SW = $clog2(SCAN_DIV + 1);
    localparam logic [SW-1:0] SMAX = SW'(SCAN_DIV - 1);

    logic [SW-1:0] scnt;
    logic          sel;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scnt <= '0;
            sel  <= 1'b0;
        end else if (scnt == SMAX) begin
            scnt <= '0;
            sel  <= ~sel;
        end else begin
            scnt <= scnt + 1'b1;
        end
    end

    always_comb begin
        a_to_g = blank[sel] ? SEG_BLANK : seg7(sel ? d1 : d0);
        an     = (&blank) ? 4'b1111 : (sel ? 4'b1101 : 4'b1110);
    end

endmodule

// File: rtl/traffic_light_gen.sv
// Two-way traffic light controller with seconds countdown display and
// flashing night mode. Define PED_REQ_EN to enable pedestrian shortening.
module traffic_light_gen
    import traffic_pkg::*;
#(
    parameter int TICK_DIV = 50_000_000,
    parameter int SCAN_DIV = 100_000,
    parameter int GREEN_T  = 20,
    parameter int YELLOW_T = 3,
    parameter int ALLRED_T = 1,
    parameter int PED_MIN  = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       night,
    input  logic       ped_req,
    output logic       R1_led,
    output logic       Y1_led,
    output logic       G1_led,
    output logic       R2_led,
    output logic       Y2_led,
    output logic       G2_led,
    output logic [6:0] a_to_g,
    output logic [3:0] an,
    output logic       dp
);

    localparam int TW = $clog2(TICK_DIV);
    localparam logic [TW-1:0] TMAX = TW'(TICK_DIV - 1);
    localparam logic [6:0] GREEN  = 7'(GREEN_T);
    localparam logic [6:0] YELLOW = 7'(YELLOW_T);
    localparam logic [6:0] ALLRED = 7'(ALLRED_T);

    logic [TW-1:0] tcnt;
    logic          tick;
    state_t        state, state_n;
    logic [6:0]    rem, rem_n;
    logic          blink, blink_n;

    assign tick = (tcnt == TMAX);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tcnt  <= '0;
            state <= S_G1;
            rem   <= GREEN;
            blink <= 1'b0;
        end else begin
            tcnt  <= tick ? '0 : tcnt + 1'b1;
            state <= state_n;
            rem   <= rem_n;
            blink <= blink_n;
        end
    end

    always_comb begin
        state_n = state;
        rem_n   = rem;
        blink_n = blink;
        if (tick) begin
            if (state == S_NIGHT) begin
                if (!night) begin
                    state_n = S_AR2;
                    rem_n   = ALLRED;
                end else begin
                    blink_n = ~blink;
                end
            end else if (rem == 7'd1) begin
                // Night mode is only entered from an all-red phase.
                case (state)
                    S_G1:    begin state_n = S_Y1;  rem_n = YELLOW; end
                    S_Y1:    begin state_n = S_AR1; rem_n = ALLRED; end
                    S_AR1:   if (night) begin state_n = S_NIGHT; blink_n = 1'b1; end
                             else       begin state_n = S_G2;    rem_n = GREEN;  end
                    S_G2:    begin state_n = S_Y2;  rem_n = YELLOW; end
                    S_Y2:    begin state_n = S_AR2; rem_n = ALLRED; end
                    S_AR2:   if (night) begin state_n = S_NIGHT; blink_n = 1'b1; end
                             else       begin state_n = S_G1;    rem_n = GREEN;  end
                    default: begin state_n = S_G1;  rem_n = GREEN;  end
                endcase
            end else begin
                rem_n = rem - 7'd1;
            end
        end
`ifdef PED_REQ_EN
        if (ped_req && (state == S_G1 || state == S_G2) && rem > 7'(PED_MIN))
            rem_n = 7'(PED_MIN);
`endif
    end

`ifndef PED_REQ_EN
    logic ped_unused;
    assign ped_unused = ped_req;
`endif

    always_comb begin
        {R1_led, Y1_led, G1_led, R2_led, Y2_led, G2_led} = 6'b000000;
        case (state)
            S_G1:    begin G1_led = 1'b1; R2_led = 1'b1; end
            S_Y1:    begin Y1_led = 1'b1; R2_led = 1'b1; end
            S_G2:    begin R1_led = 1'b1; G2_led = 1'b1; end
            S_Y2:    begin R1_led = 1'b1; Y2_led = 1'b1; end
            S_NIGHT: begin Y1_led = blink; Y2_led = blink; end
            default: begin R1_led = 1'b1; R2_led = 1'b1; end
        endcase
    end

    logic [3:0] tens, units;
    logic [1:0] blank;

    assign tens  = 4'(rem / 7'd10);
    assign units = 4'(rem % 7'd10);
    assign blank = (state == S_NIGHT) ? 2'b11 : {tens == 4'd0, 1'b0};
    assign dp    = 1'b1;

    seg_scan4 #(.SCAN_DIV(SCAN_DIV)) u_scan (
        .clk    (clk),
        .reset  (reset),
        .d0     (units),
        .d1     (tens),
        .blank  (blank),
        .a_to_g (a_to_g),
        .an     (an)
    );

endmodule
